// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// Module   : iter_divider
// Purpose  : 32-bit radix-2 restoring divider, 33-cycle busy window, {HI, LO}
//            result for the execute-stage ALU.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module iter_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] result,
   output logic        done
);

   localparam logic [1:0] C_OP_SIGNED   = 2'b10;
   localparam logic [1:0] C_OP_UNSIGNED = 2'b01;
   localparam logic [4:0] C_LAST_ITER   = 5'd31;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_done;
   logic [63:0] r_result;
   logic [4:0]  r_cnt;
   logic        r_signed;
   logic        r_sign_a;
   logic        r_sign_b;
   logic [31:0] r_dvs;
   logic [31:0] r_rem;
   logic [31:0] r_quo;

   logic        w_accept;
   logic        w_op_signed;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_shift;
   logic [32:0] w_trial;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   // ---------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------
   assign w_op_signed = (div_op == C_OP_SIGNED);
   assign w_accept    = (r_state == S_IDLE) &&
                        ((div_op == C_OP_SIGNED) || (div_op == C_OP_UNSIGNED));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_CALC;
         S_CALC: if (r_cnt == C_LAST_ITER) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == S_IDLE);
      end
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   assign w_mag_a = (w_op_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
   assign w_mag_b = (w_op_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

   // The partial remainder is always below the divisor, so its 33rd bit is
   // only ever non-zero in the shifted working value, never in storage.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_trial = w_shift - {1'b0, r_dvs};

   assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (~r_quo + 32'd1) : r_quo;
   assign w_rem_fix = r_sign_a ? (~r_rem + 32'd1) : r_rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= 64'h0;
         r_cnt    <= 5'd0;
         r_signed <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_dvs    <= 32'h0;
         r_rem    <= 32'h0;
         r_quo    <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_signed <= w_op_signed;
                  r_sign_a <= w_op_signed & dividend[31];
                  r_sign_b <= w_op_signed & divisor[31];
                  r_dvs    <= w_mag_b;
                  r_rem    <= 32'h0;
                  r_quo    <= w_mag_a;
                  r_cnt    <= 5'd0;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 5'd1;
               if (!w_trial[32]) begin
                  r_rem <= w_trial[31:0];
                  r_quo <= {r_quo[30:0], 1'b1};
               end else begin
                  r_rem <= w_shift[31:0];
                  r_quo <= {r_quo[30:0], 1'b0};
               end
            end
            S_FIX: begin
               r_result <= {w_rem_fix, w_quo_fix};
            end
            default: begin
               r_cnt <= 5'd0;
            end
         endcase
      end
   end

   assign result = r_result;
   assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ----------------------------------------------------------------------------
// Module   : tb_iter_divider
// Purpose  : Directed self-checking bench for iter_divider.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_iter_divider;

   logic        clk;
   logic        rst;
   logic [1:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [63:0] result;
   logic        done;

   int n_vec;
   int n_err;
   int n_rise;

   iter_divider dut (
      .clk      (clk),
      .rst      (rst),
      .div_op   (div_op),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge done) n_rise++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the following posedge is the accept edge.
   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      div_op   = op;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      div_op   = 2'b00;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Counts negedges with done low; returns on the first negedge with done high.
   task automatic wait_done(output int busy, output int held_err);
      logic [63:0] snap;
      snap     = result;
      busy     = 0;
      held_err = 0;
      @(negedge clk);
      while (!done && busy < 100) begin
         busy++;
         if (result !== snap) held_err++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
      int busy;
      int held_err;
      start(op, a, b);
      wait_done(busy, held_err);
      check({tag, "_busy"}, 64'(busy), 64'd33);
      check({tag, "_held"}, 64'(held_err), 64'd0);
      check(tag, result, exp);
   endtask

   initial begin
      int busy;
      int held_err;
      n_vec    = 0;
      n_err    = 0;
      n_rise   = 0;
      div_op   = 2'b00;
      dividend = 32'h0;
      divisor  = 32'h0;
      rst      = 1'b1;
      #1 rst   = 1'b0;
      #2;
      check("rst_done", 64'(done), 64'd1);
      check("rst_result", result, 64'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);

      // Reserved opcode must not start a divide
      div_op = 2'b11; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk);
      #1 div_op = 2'b00;
      @(negedge clk);
      check("op11_ignored", 64'(done), 64'd1);

      run("u_100_7",   2'b01, 32'd100,       32'd7,         64'h0000_0002_0000_000E);
      run("s_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD);
      run("s_7_m2",    2'b10, 32'h7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run("s_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run("u_max_1",   2'b01, 32'hFFFF_FFFF, 32'h1,         64'h0000_0000_FFFF_FFFF);
      run("u_fff9_2",  2'b01, 32'hFFFF_FFF9, 32'h2,         64'h0000_0001_7FFF_FFFC);
      run("u_div0",    2'b01, 32'h1234,      32'h0,         64'h0000_1234_FFFF_FFFF);
      run("s_m5_div0", 2'b10, 32'hFFFF_FFFB, 32'h0,         64'hFFFF_FFFB_0000_0001);

      // Request during busy is dropped
      n_rise = 0;
      start(2'b01, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      div_op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk);
      #1 div_op = 2'b00;
      wait_done(busy, held_err);
      repeat (40) @(negedge clk);
      check("busy_ign_result", result, 64'h0000_0002_0000_000E);
      check("busy_ign_rises", 64'(n_rise), 64'd1);

      // Asynchronous reset between clock edges mid-operation
      start(2'b01, 32'd100, 32'd7);
      repeat (15) @(negedge clk);
      check("pre_rst_busy", 64'(done), 64'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_done", 64'(done), 64'd1);
      check("arst_result", result, 64'h0);
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      run("post_rst_9_3", 2'b01, 32'd9, 32'd3, 64'h0000_0000_0000_0003);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
